period_gen: RTL and testbench
=============================

Name: period_gen

Overview:
- Square-wave generator: converts an 8-bit frequency class code (1..10) into a 50%-duty square wave on one output.
- Code n produces a period of BASE_PERIOD/n clocks. With a 10 MHz clk and the default, code n gives n×10 kHz.
- Serves as the stimulus source for the period-measurement path and as the tone output of the system.
- Code changes take effect only at period boundaries, so the output never glitches.

Parameters:
- BASE_PERIOD, 1000, period in clk cycles for code 1; range 20..65535.
- MAX_CODE, 10, highest valid code; codes 1..MAX_CODE are valid.

Ports:
- clk  input  1  system clock (10 MHz nominal)
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run request; level-sensitive
- freq  input  8  requested frequency class code
- sigout  output  1  generated square wave
- active  output  1  high while generating (state HIGH or LOW)
- cur_code  output  8  code currently being generated; 0 when idle
- period_tick  output  1  one-cycle pulse on the last clock of each completed period

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately, including mid-period. All outputs go to 0; state goes to IDLE; counters and the accumulator clear.
- Period table:
  - Computed at elaboration: P(n) = BASE_PERIOD / n, integer truncation, for n = 1..MAX_CODE.
  - High phase H = P - P/2. Low phase L = P/2.
  - Default values: P = 1000, 500, 333, 250, 200, 166, 142, 125, 111, 100.
  - Code 3 gives H=167, L=166.
- Phase counter: 16-bit down-counter; no runtime divider.
- Valid code: 1 <= freq <= MAX_CODE. freq = 0 or freq > MAX_CODE is invalid.
- States: IDLE, HIGH, LOW.
- IDLE:
  - sigout=0, active=0, cur_code=0.
  - If en=1 and freq is valid, latch freq into cur_code, load H, and go to HIGH on the next edge. sigout rises on the same edge.
  - Otherwise stay in IDLE.
- HIGH:
  - sigout=1 for exactly H cycles.
  - On the last cycle, load L and go to LOW.
- LOW:
  - sigout=0 for exactly L cycles.
  - period_tick=1 on the last LOW cycle only.
  - At that boundary, re-sample en and freq:
    - en=1, freq valid: latch freq (may differ from the old code), load the new H, go to HIGH. The new period starts with no gap.
    - Otherwise: go to IDLE. cur_code becomes 0 and active becomes 0 on that edge.
- en and freq are ignored inside HIGH and LOW. A change takes effect only at the next period boundary.
- Dropping en mid-period always completes the current period.
- Latency: en rising with a valid freq while IDLE gives sigout=1 at the first following clk edge.
- All outputs are registered.

Optional Feature:
- Macro: GEN_FRAC_PERIOD_EN
- Defined:
  - Per-code remainder R(n) = BASE_PERIOD mod n, elaboration-time table.
  - Accumulator acc, 8-bit. At each period boundary, acc += R. If the result >= n, subtract n and add one extra clock to the upcoming LOW phase.
  - Effect: the long-run average period is exactly BASE_PERIOD/n.
  - acc clears on reset, on entering IDLE, and whenever the latched code changes.
  - Example, code 3: periods repeat 333, 333, 334.
- Undefined: fixed truncated periods only; no accumulator logic is present.

Test Plan:
- rst_n released, en=1, freq=1 → sigout high 500 clk, low 500 clk, repeating; period_tick every 1000 clk on the last low cycle; cur_code=1, active=1.
- freq=3 → high 167, low 166, period 333; freq=7 → high 71, low 71, period 142.
- freq changed 1→10 midway through a HIGH phase → current 1000-clk period completes unchanged; the next period is high 50, low 50; cur_code changes to 10 exactly at the boundary.
- en dropped at clk 200 of a code-2 period → the period finishes (high 250, low 250); then IDLE with sigout=0, active=0, cur_code=0. freq=0 or freq=11 with en=1 → stays IDLE, no edges on sigout.
- rst_n pulsed low mid-HIGH → sigout, active, cur_code and period_tick drop to 0 without waiting for a clk edge; after release, a fresh period starts with a full H.
- With GEN_FRAC_PERIOD_EN, code 3 for 6 periods → lengths 333, 333, 334, 333, 333, 334; total 2000 clk. Switching to code 6 → acc cleared; lengths 166, 167, 167, 166, 167, 167.

Source files
------------

// File: rtl/period_gen.sv
// Square-wave tone generator: code n (1..MAX_CODE) gives a 50%-duty wave of BASE_PERIOD/n clocks.
// Optional macro GEN_FRAC_PERIOD_EN spreads the BASE_PERIOD mod n remainder so the average period is exact.
module period_gen #(
  parameter int BASE_PERIOD = 1000,
  parameter int MAX_CODE    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] freq,
  output logic       sigout,
  output logic       active,
  output logic [7:0] cur_code,
  output logic       period_tick
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [7:0] MAX_CODE_B = 8'(MAX_CODE);

  logic [15:0] h_tab [256];
  logic [15:0] l_tab [256];
`ifdef GEN_FRAC_PERIOD_EN
  logic [7:0]  r_tab [256];
`endif

  // Phase lengths are elaboration-time constants indexed by code; no runtime divider.
  for (genvar g = 0; g < 256; g++) begin : g_tab
    if (g >= 1 && g <= MAX_CODE) begin : g_valid
      localparam int P = BASE_PERIOD / g;
      assign h_tab[g] = 16'(P - P / 2);
      assign l_tab[g] = 16'(P / 2);
`ifdef GEN_FRAC_PERIOD_EN
      assign r_tab[g] = 8'(BASE_PERIOD % g);
`endif
    end else begin : g_unused
      assign h_tab[g] = '0;
      assign l_tab[g] = '0;
`ifdef GEN_FRAC_PERIOD_EN
      assign r_tab[g] = '0;
`endif
    end
  end

  logic [1:0]  state, nxt_state;
  logic [15:0] cnt, nxt_cnt;
  logic [7:0]  nxt_code;
  logic        valid, start;
  logic [15:0] low_load;

  assign valid = en && (freq != 8'd0) && (freq <= MAX_CODE_B);

`ifdef GEN_FRAC_PERIOD_EN
  logic [7:0] acc;
  logic       extra;
  logic [7:0] acc_base;
  logic [8:0] acc_sum;
  logic       acc_wrap;

  // Accumulator restarts from zero whenever a different code is latched (idle code is 0).
  assign acc_base = (freq != cur_code) ? 8'd0 : acc;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, r_tab[freq]};
  assign acc_wrap = (acc_sum >= {1'b0, freq});
  assign low_load = l_tab[cur_code] - 16'd1 + {15'd0, extra};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 8'd0;
      extra <= 1'b0;
    end else if (start) begin
      acc   <= acc_wrap ? 8'(acc_sum - {1'b0, freq}) : acc_sum[7:0];
      extra <= acc_wrap;
    end else if (nxt_state == ST_IDLE) begin
      acc   <= 8'd0;
      extra <= 1'b0;
    end
  end
`else
  assign low_load = l_tab[cur_code] - 16'd1;
`endif

  always_comb begin
    start     = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_code  = cur_code;
    case (state)
      ST_IDLE: begin
        if (valid) start = 1'b1;
      end
      ST_HIGH: begin
        nxt_cnt = cnt - 16'd1;
        if (cnt == 16'd0) begin
          nxt_state = ST_LOW;
          nxt_cnt   = low_load;
        end
      end
      ST_LOW: begin
        nxt_cnt = cnt - 16'd1;
        if (cnt == 16'd0) begin
          if (valid) begin
            start = 1'b1;
          end else begin
            nxt_state = ST_IDLE;
            nxt_code  = 8'd0;
            nxt_cnt   = 16'd0;
          end
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_code  = 8'd0;
        nxt_cnt   = 16'd0;
      end
    endcase
    if (start) begin
      nxt_state = ST_HIGH;
      nxt_cnt   = h_tab[freq] - 16'd1;
      nxt_code  = freq;
    end
  end

  // Outputs are registered copies of the next-state decode, so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 16'd0;
      cur_code    <= 8'd0;
      sigout      <= 1'b0;
      active      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      cur_code    <= nxt_code;
      sigout      <= (nxt_state == ST_HIGH);
      active      <= (nxt_state != ST_IDLE);
      period_tick <= (nxt_state == ST_LOW) && (nxt_cnt == 16'd0);
    end
  end

endmodule

// File: tb/tb_period_gen.sv
// Directed bench for period_gen: phase lengths, code switching, en drop, invalid codes, async reset.
module tb_period_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] freq;
  logic       sigout;
  logic       active;
  logic [7:0] cur_code;
  logic       period_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  period_gen #(.BASE_PERIOD(1000), .MAX_CODE(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .freq        (freq),
    .sigout      (sigout),
    .active      (active),
    .cur_code    (cur_code),
    .period_tick (period_tick)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts on the first high sample; returns positioned on the first sample after the period.
  task automatic measure(output int hi, output int lo, output int ticks, output int tick_pos);
    hi = 0; lo = 0; ticks = 0; tick_pos = -1;
    while (sigout === 1'b1 && hi < 5000) begin
      hi++;
      if (period_tick === 1'b1) ticks++;
      step();
    end
    while (sigout === 1'b0 && active === 1'b1 && lo < 5000) begin
      lo++;
      if (period_tick === 1'b1) begin
        ticks++;
        tick_pos = lo;
      end
      step();
    end
    if (hi >= 5000 || lo >= 5000) check_eq("measure_timeout", 1, 0);
  endtask

  task automatic period_check(input string tag, input int exp_hi, input int exp_lo);
    int hi, lo, ticks, tick_pos;
    measure(hi, lo, ticks, tick_pos);
    check_eq({tag, "_high"}, hi, exp_hi);
    check_eq({tag, "_low"}, lo, exp_lo);
    check_eq({tag, "_ticks"}, ticks, 1);
    check_eq({tag, "_tick_pos"}, tick_pos, lo);
  endtask

  initial begin
    int hi, lo, ticks, tick_pos, bad, total;
    int exp3 [6];
    int exp6 [6];
    exp3 = '{333, 333, 334, 333, 333, 334};
    exp6 = '{166, 167, 167, 166, 167, 167};

    rst_n = 1'b0; en = 1'b0; freq = 8'd0;
    repeat (3) step();
    check_eq("rst_sigout", sigout, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_cur_code", cur_code, 0);
    check_eq("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_active", active, 0);

    // First edge after a valid request raises sigout.
    en = 1'b1; freq = 8'd1;
    step();
    check_eq("start_sigout", sigout, 1);
    check_eq("start_active", active, 1);
    check_eq("start_code", cur_code, 1);
    period_check("code1_p1", 500, 500);
    period_check("code1_p2", 500, 500);

    // Change during HIGH: current period unchanged, new code exactly at boundary.
    step(); step();
    freq = 8'd10;
    check_eq("pre_switch_code", cur_code, 1);
    measure(hi, lo, ticks, tick_pos);
    check_eq("switch_high", hi + 2, 500);
    check_eq("switch_low", lo, 500);
    check_eq("post_switch_code", cur_code, 10);
    period_check("code10", 50, 50);

    freq = 8'd3;
    period_check("code10_tail", 50, 50);
    check_eq("code3_code", cur_code, 3);
    period_check("code3", 167, 166);
    freq = 8'd7;
    measure(hi, lo, ticks, tick_pos);
    period_check("code7", 71, 71);

    // en dropped 200 clocks into a code-2 period: the period still completes.
    freq = 8'd2;
    measure(hi, lo, ticks, tick_pos);
    check_eq("code2_code", cur_code, 2);
    repeat (200) step();
    en = 1'b0;
    measure(hi, lo, ticks, tick_pos);
    check_eq("drop_high_rest", hi, 50);
    check_eq("drop_low", lo, 250);
    check_eq("drop_tick", ticks, 1);
    check_eq("drop_sigout", sigout, 0);
    check_eq("drop_active", active, 0);
    check_eq("drop_code", cur_code, 0);

    en = 1'b1;
    foreach (exp3[k]) begin
      bad = 0;
      freq = (k % 2 == 0) ? 8'd0 : 8'd11;
      repeat (20) begin
        step();
        if (sigout !== 1'b0 || active !== 1'b0 || cur_code !== 8'd0) bad++;
      end
      check_eq((k % 2 == 0) ? "invalid_code0" : "invalid_code11", bad, 0);
    end

    // Asynchronous reset mid-HIGH, then a full fresh period.
    freq = 8'd4;
    step();
    check_eq("code4_start", sigout, 1);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check_eq("async_sigout", sigout, 0);
    check_eq("async_active", active, 0);
    check_eq("async_code", cur_code, 0);
    check_eq("async_tick", period_tick, 0);
    #1 rst_n = 1'b1;
    step();
    check_eq("restart_sigout", sigout, 1);
    period_check("code4_fresh", 125, 125);

`ifdef GEN_FRAC_PERIOD_EN
    freq = 8'd3;
    measure(hi, lo, ticks, tick_pos);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) freq = 8'd6;
      measure(hi, lo, ticks, tick_pos);
      check_eq("frac3_period", hi + lo, exp3[i]);
      total += hi + lo;
    end
    check_eq("frac3_total", total, 2000);
    for (int i = 0; i < 6; i++) begin
      measure(hi, lo, ticks, tick_pos);
      check_eq("frac6_period", hi + lo, exp6[i]);
    end
`else
    total = 0;
    for (int i = 0; i < 2; i++) begin
      measure(hi, lo, ticks, tick_pos);
      total += hi + lo;
    end
    check_eq("code4_total", total, 500);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
